alu_min_bist: RTL and testbench
===============================

# alu_min_bist

Sequential built-in self-test controller for the minimal 16-bit ALU: drives its operand/opcode inputs from a 33-bit LFSR, sweeps all eight opcodes, and samples and compares the outputs of two ALU instances (behavioural vs. synthesized). It reports a pass/fail verdict, a mismatch count and the first failing vector. It sits beside the ALU pair at the consumer end of the `inA`/`inB`/`inc`/`opc` → `w`/`zer`/`neg` interface.

## Interface
- `VEC_PER_OP`, default 8: vectors applied per opcode, valid range 1..255.
- `SEED`, default 33'h1_2345_6789: LFSR seed; an all-zero value is replaced by 33'h1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: single-cycle run request; accepted only in IDLE or DONE.
- `inA`, `inB` output, 16 bits each: ALU operands, registered.
- `inc` output, 1 bit: ALU carry-in, registered.
- `opc` output, 3 bits: ALU opcode, registered.
- `w_a`, `zer_a`, `neg_a` input, 16/1/1 bits: outputs of ALU instance A.
- `w_b`, `zer_b`, `neg_b` input, 16/1/1 bits: outputs of ALU instance B.
- `busy` output, 1 bit: run in progress.
- `done` output, 1 bit: level, held high from run end until the next `start` or `rst`.
- `pass` output, 1 bit: valid while `done`=1; 1 means zero mismatches.
- `err_cnt` output, 8 bits: mismatch count, saturates at 255.
- `fail_vec` output, 36 bits: {opc, inA, inB, inc} of the first mismatch (see Configuration).

## Operation
- State machine has four states: IDLE, DRIVE, SAMPLE and DONE.
  - IDLE → DRIVE on `start`. On entry: LFSR loads `SEED`, `opc`=0, vector counter=0, `err_cnt`=0 and the first-fail flag is cleared.
  - DRIVE: {`inA`,`inB`,`inc`} ← LFSR[32:0], MSB first into `inA`. The LFSR advances one step. Goes to SAMPLE.
  - SAMPLE: compares {`w`,`zer`,`neg`} of A against B. Any bit difference is a mismatch and increments `err_cnt` (saturating). The first mismatch also records `fail_vec`.
  - Leaving SAMPLE:
    - If vector counter = `VEC_PER_OP`-1: counter ← 0, `opc` ← `opc`+1.
    - Otherwise: counter increments.
    - If `opc`=7 and the counter was at its last value, go to DONE; otherwise go to DRIVE.
  - DONE → DRIVE on `start`, with the same reinitialisation as from IDLE.
- `start` is ignored during DRIVE and SAMPLE.
- LFSR is Fibonacci, polynomial x^33+x^20+1. Next state = {s[31:0], s[32]^s[19]}.
- `opc` wraps from 7 to 0 only when the run ends; it reads 0 in DONE.
- `pass` = (`err_cnt`==0) and is registered on entry to DONE.

## Timing
- Reset values: `inA`=`inB`=0, `inc`=0, `opc`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0. State resets to IDLE.
- An ALU input change becomes visible the cycle after DRIVE. The ALU is combinational, so SAMPLE compares the settled outputs one cycle later.
- Each vector takes 2 cycles. A run takes 16·`VEC_PER_OP` cycles from the `start` edge to the edge that sets `done`. The default is 128 cycles.
- `busy`=1 exactly in DRIVE/SAMPLE. `done` and `busy` are never both 1.
- `rst` mid-run aborts immediately to reset values. No partial verdict is kept.
- If `start` arrives in the same cycle as entry to DONE, it is ignored.
- `err_cnt` at 255 stays at 255; `pass` stays 0.

## Configuration
- Controlled by macro `ALU_MIN_BIST_FAILLOG_EN`.
- Defined: `fail_vec` captures the first mismatching vector and holds it until the next `start` or `rst`.
- Undefined: capture logic is not compiled, `fail_vec` is tied to 0, and `err_cnt`/`pass` behave identically.

## Structure
- Shared package `alu_min_pkg`:
  - DATA_W=16, OPC_W=3, LFSR_W=33, LFSR_TAP=19
  - state enum {IDLE, DRIVE, SAMPLE, DONE}
  - default seed constant
- Sub-module `alu_min_lfsr`: 33-bit LFSR with load/step enables and zero-seed protection. It is the only sub-module.
- The controller FSM, counters and comparator live in the top level.

## Test plan
- Identical ALUs (`w_b`=`w_a` etc.), `VEC_PER_OP`=8, pulse `start` → `done` rises 128 cycles later, `pass`=1, `err_cnt`=0, `fail_vec`=0.
- Instance B with `neg_b` forced to 1 → every vector where `neg_a`=0 counts. Check `err_cnt` against the reference model count. `fail_vec` equals the first such vector; the first vector is at `opc`=0 and is computed from `SEED`.
- B's `w_b` bit 0 inverted only when `opc`=5 → `err_cnt`=8, `pass`=0, `fail_vec[35:33]`=3'b101.
- `SEED`=0 → first driven vector equals {`inA`,`inB`,`inc`} = 33'h1; LFSR never locks up.
- `rst` asserted at cycle 50 of a run → all outputs return to reset values the same cycle. A new `start` then yields a full 128-cycle run.
- `VEC_PER_OP`=255 with always-mismatching B → `err_cnt` saturates at 255, `pass`=0. With the macro undefined, `fail_vec` stays 0.

Source files
------------

// File: rtl/alu_min_pkg.sv
// Shared constants, state encoding and LFSR helpers for the minimal-ALU BIST controller.
package alu_min_pkg;

  localparam int DATA_W   = 16;
  localparam int OPC_W    = 3;
  localparam int LFSR_W   = 33;
  localparam int LFSR_TAP = 19;
  localparam int CNT_W    = 8;
  localparam int FAIL_W   = OPC_W + 2 * DATA_W + 1;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 33'h1_2345_6789;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Fibonacci step for x^33 + x^20 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_TAP]};
  endfunction

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == {LFSR_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/alu_min_bist_if.sv
// Stimulus/response bundle between the BIST controller and the ALU pair under test.
interface alu_min_bist_if;
  import alu_min_pkg::*;

  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic              inc;
  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] w_a;
  logic              zer_a;
  logic              neg_a;
  logic [DATA_W-1:0] w_b;
  logic              zer_b;
  logic              neg_b;

  modport master (
    output inA, inB, inc, opc,
    input  w_a, zer_a, neg_a, w_b, zer_b, neg_b
  );

  modport slave (
    input  inA, inB, inc, opc,
    output w_a, zer_a, neg_a, w_b, zer_b, neg_b
  );

endinterface

// File: rtl/alu_min_lfsr.sv
// 33-bit pattern LFSR with load/step enables; an all-zero seed is replaced by 1 so it cannot lock up.
module alu_min_lfsr
  import alu_min_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

  // Load has priority so a restart always begins from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_EFF;
    end else if (load) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/alu_min_bist.sv
// BIST controller for the minimal 16-bit ALU pair: LFSR stimulus, opcode sweep, A/B compare.
// Optional first-failure capture is compiled in with `define ALU_MIN_BIST_FAILLOG_EN.
module alu_min_bist
  import alu_min_pkg::*;
#(
  parameter int                VEC_PER_OP = 8,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  alu_min_bist_if.master        alu,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [FAIL_W-1:0]     fail_vec
);

  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_PER_OP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   vec_cnt;
  logic [CNT_W-1:0]   err_nx;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               init_run;
  logic               drive_en;
  logic               sample_en;
  logic               run_end;
  logic               last_vec;
  logic               mismatch;

  assign last_vec = (vec_cnt == VEC_LAST);
  assign mismatch = ({alu.w_a, alu.zer_a, alu.neg_a} != {alu.w_b, alu.zer_b, alu.neg_b});

  alu_min_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (init_run),
    .step  (drive_en),
    .state (lfsr_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_nx  = state;
    init_run  = 1'b0;
    drive_en  = 1'b0;
    sample_en = 1'b0;
    run_end   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = DRIVE;
          init_run = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      DRIVE: begin
        drive_en = 1'b1;
        state_nx = SAMPLE;
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (last_vec && (alu.opc == 3'd7)) begin
          state_nx = DONE;
          run_end  = 1'b1;
        end else begin
          state_nx = DRIVE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Saturating mismatch count; pass must see the count including the final sample
  always_comb begin
    err_nx = err_cnt;
    if (init_run) begin
      err_nx = CNT_ZERO;
    end else if (sample_en && mismatch && (err_cnt != CNT_MAX)) begin
      err_nx = err_cnt + 8'd1;
    end else begin
      err_nx = err_cnt;
    end
  end

  // Stimulus registers, vector counter and opcode sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu.inA <= 16'h0000;
      alu.inB <= 16'h0000;
      alu.inc <= 1'b0;
      alu.opc <= 3'd0;
      vec_cnt <= CNT_ZERO;
    end else if (init_run) begin
      alu.opc <= 3'd0;
      vec_cnt <= CNT_ZERO;
    end else if (drive_en) begin
      {alu.inA, alu.inB, alu.inc} <= lfsr_q;
    end else if (sample_en) begin
      if (last_vec) begin
        vec_cnt <= CNT_ZERO;
        alu.opc <= alu.opc + 3'd1;
      end else begin
        vec_cnt <= vec_cnt + 8'd1;
      end
    end else begin
      vec_cnt <= vec_cnt;
    end
  end

  // Status outputs, registered from the next state so busy/done are mutually exclusive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= CNT_ZERO;
    end else begin
      busy    <= (state_nx == DRIVE) || (state_nx == SAMPLE);
      done    <= (state_nx == DONE);
      err_cnt <= err_nx;
      if (init_run) begin
        pass <= 1'b0;
      end else if (run_end) begin
        pass <= (err_nx == CNT_ZERO);
      end else begin
        pass <= pass;
      end
    end
  end

`ifdef ALU_MIN_BIST_FAILLOG_EN
  logic fail_seen;

  // Latch the first mismatching vector of the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_seen <= 1'b0;
      fail_vec  <= {FAIL_W{1'b0}};
    end else if (init_run) begin
      fail_seen <= 1'b0;
      fail_vec  <= {FAIL_W{1'b0}};
    end else if (sample_en && mismatch && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_vec  <= {alu.opc, alu.inA, alu.inB, alu.inc};
    end else begin
      fail_seen <= fail_seen;
      fail_vec  <= fail_vec;
    end
  end
`else
  assign fail_vec = {FAIL_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_min_bist.sv
// Self-checking bench for alu_min_bist: table of run scenarios plus reset, zero-seed and saturation sequences.
`timescale 1ns/1ps
module tb_alu_min_bist;

  localparam logic [32:0] SEED0 = 33'h1_2345_6789;

  logic        clk;
  logic        rst;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [7:0]  err_v   [3];
  logic [35:0] fv_v    [3];
  logic [32:0] vec_v   [3];
  logic [2:0]  opc_v   [3];
  int          mode;
  int          checks;
  int          failures;

  alu_min_bist_if if0 ();
  alu_min_bist_if if1 ();
  alu_min_bist_if if2 ();

  alu_min_bist #(.VEC_PER_OP(8), .SEED(SEED0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .alu(if0.master),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]), .fail_vec(fv_v[0]));

  alu_min_bist #(.VEC_PER_OP(1), .SEED(33'h0)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .alu(if1.master),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]), .fail_vec(fv_v[1]));

  alu_min_bist #(.VEC_PER_OP(255), .SEED(SEED0)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .alu(if2.master),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]), .fail_vec(fv_v[2]));

  assign vec_v[0] = {if0.inA, if0.inB, if0.inc};
  assign vec_v[1] = {if1.inA, if1.inB, if1.inc};
  assign vec_v[2] = {if2.inA, if2.inB, if2.inc};
  assign opc_v[0] = if0.opc;
  assign opc_v[1] = if1.opc;
  assign opc_v[2] = if2.opc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {w, zer, neg}
  function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] op);
    logic [15:0] w;
    case (op)
      3'd0:    w = a + b + {15'd0, c};
      3'd1:    w = a - b - {15'd0, c};
      3'd2:    w = a & b;
      3'd3:    w = a | b;
      3'd4:    w = a ^ b;
      3'd5:    w = ~a;
      3'd6:    w = {a[14:0], c};
      default: w = b;
    endcase
    return {w, (w == 16'h0000), w[15]};
  endfunction

  // Instance B behaviour per scenario
  function automatic logic [17:0] b_model(input int m, input logic [17:0] ra, input logic [2:0] op);
    logic [17:0] rb;
    rb = ra;
    case (m)
      1:       rb[0] = 1'b1;
      2:       if (op == 3'd5) rb[2] = ~ra[2];
      3:       rb[17:2] = ~ra[17:2];
      default: rb = ra;
    endcase
    return rb;
  endfunction

  always_comb begin
    logic [17:0] ra0, ra1, ra2;
    ra0 = alu_ref(if0.inA, if0.inB, if0.inc, if0.opc);
    ra1 = alu_ref(if1.inA, if1.inB, if1.inc, if1.opc);
    ra2 = alu_ref(if2.inA, if2.inB, if2.inc, if2.opc);
    {if0.w_a, if0.zer_a, if0.neg_a} = ra0;
    {if0.w_b, if0.zer_b, if0.neg_b} = b_model(mode, ra0, if0.opc);
    {if1.w_a, if1.zer_a, if1.neg_a} = ra1;
    {if1.w_b, if1.zer_b, if1.neg_b} = ra1;
    {if2.w_a, if2.zer_a, if2.neg_a} = ra2;
    {if2.w_b, if2.zer_b, if2.neg_b} = b_model(3, ra2, if2.opc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent walk through the vector sequence for one run
  task automatic model_run(input int m, input logic [32:0] seed, input int v,
                           output int err, output logic [35:0] fv);
    logic [32:0] s;
    logic [17:0] ra;
    logic [2:0]  opl;
    bit          seen;
    err  = 0;
    fv   = 36'h0;
    seen = 1'b0;
    s    = (seed == 33'h0) ? 33'h1 : seed;
    for (int op = 0; op < 8; op++) begin
      opl = op[2:0];
      for (int k = 0; k < v; k++) begin
        ra = alu_ref(s[32:17], s[16:1], s[0], opl);
        if (ra != b_model(m, ra, opl)) begin
          if (err < 255) err++;
          if (!seen) begin
            seen = 1'b1;
            fv   = {opl, s};
          end
        end
        s = {s[31:0], s[32] ^ s[19]};
      end
    end
  endtask

  // Pulse start, check first vector, count edges until done, optional stray start mid-run
  task automatic run_dut(input int d, input logic [32:0] exp_first, input int exp_len, input int stray_at);
    int cycles;
    bit overlap;
    bit lockup;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    chk("done_clr_on_start", {busy_v[d], done_v[d]}, 2'b10);
    cycles  = 0;
    overlap = 1'b0;
    lockup  = 1'b0;
    while (done_v[d] !== 1'b1 && cycles < exp_len + 64) begin
      start_v[d] = (cycles == stray_at);
      @(posedge clk);
      cycles++;
      #1;
      if (busy_v[d] && done_v[d]) overlap = 1'b1;
      if (vec_v[d] == 33'h0) lockup = 1'b1;
      if (cycles == 1) begin
        chk("first_vec", vec_v[d], exp_first);
        chk("first_opc", opc_v[d], 3'd0);
      end
    end
    start_v[d] = 1'b0;
    chk("run_len", cycles, exp_len);
    chk("busy_done_excl", overlap, 1'b0);
    chk("lfsr_nonzero", lockup, 1'b0);
    chk("opc_in_done", opc_v[d], 3'd0);
    chk("busy_in_done", busy_v[d], 1'b0);
  endtask

  typedef struct {
    int          mode;
    int          exp_err;
    bit          exp_pass;
    logic [35:0] exp_fv;
  } scen_t;

  scen_t tbl [4];

  initial begin
    int          merr;
    logic [35:0] mfv;
    checks   = 0;
    failures = 0;
    mode     = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    model_run(1, SEED0, 8, merr, mfv);
    tbl[0] = '{0, 0, 1'b1, 36'h0};
    tbl[1] = '{1, merr, (merr == 0), mfv};
    model_run(2, SEED0, 8, merr, mfv);
    tbl[2] = '{2, 8, 1'b0, mfv};
    tbl[3] = '{3, 64, 1'b0, {3'd0, SEED0}};
`ifndef ALU_MIN_BIST_FAILLOG_EN
    for (int i = 0; i < 4; i++) tbl[i].exp_fv = 36'h0;
`endif

    #23;
    chk("rst_vec_opc", {vec_v[0], opc_v[0]}, 36'h0);
    chk("rst_status", {busy_v[0], done_v[0], pass_v[0], err_v[0]}, 11'h0);
    chk("rst_fail_vec", fv_v[0], 36'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_dut(0, SEED0, 128, (i == 1) ? 20 : -1);
      chk("err_cnt", err_v[0], tbl[i].exp_err);
      chk("pass", pass_v[0], tbl[i].exp_pass);
      chk("fail_vec", fv_v[0], tbl[i].exp_fv);
      if (tbl[i].mode == 2) chk("fail_opc_hi", fv_v[0][35:33], tbl[i].exp_fv[35:33]);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", {done_v[0], pass_v[0], err_v[0]}, {1'b1, tbl[i].exp_pass, 8'(tbl[i].exp_err)});
    end

    // Abort a run at cycle 50 with rst, then a clean full run
    mode = 3;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("midrun_busy", busy_v[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_vec_opc", {vec_v[0], opc_v[0]}, 36'h0);
    chk("abort_status", {busy_v[0], done_v[0], pass_v[0], err_v[0]}, 11'h0);
    chk("abort_fail_vec", fv_v[0], 36'h0);
    @(negedge clk);
    rst  = 1'b0;
    mode = 0;
    run_dut(0, SEED0, 128, -1);
    chk("post_abort_pass", {pass_v[0], err_v[0]}, {1'b1, 8'd0});

    // Zero seed, one vector per opcode
    run_dut(1, 33'h1, 16, -1);
    chk("zero_seed_pass", {pass_v[1], err_v[1]}, {1'b1, 8'd0});

    // 255 vectors per opcode, every one mismatching
    run_dut(2, SEED0, 4080, 100);
    chk("sat_err_cnt", err_v[2], 8'd255);
    chk("sat_pass", pass_v[2], 1'b0);
`ifdef ALU_MIN_BIST_FAILLOG_EN
    chk("sat_fail_vec", fv_v[2], {3'd0, SEED0});
`else
    chk("sat_fail_vec", fv_v[2], 36'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
